// File: rtl/circ_vec_loader.sv
// circ_vec_loader: serial valid/ready word stream -> parallel vector via a 2-bank ping-pong buffer.
// Optional build macro CIRC_VEC_LOADER_CANON_EN folds 2^31-1 to 0 on store (WORD_WIDTH == 31 only).
module circ_vec_loader #(
    parameter int WORD_WIDTH = 31,
    parameter int MTX_SIZE   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_WIDTH-1:0]         in_word,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_flush,
    output logic [WORD_WIDTH-1:0]         vec [0:MTX_SIZE-1],
    output logic                          vec_valid,
    input  logic                          vec_ready,
    output logic [$clog2(MTX_SIZE):0]     fill_cnt
);

    localparam int IDX_W = $clog2(MTX_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MTX_SIZE - 1);

    function automatic logic [WORD_WIDTH-1:0] canon_word(input logic [WORD_WIDTH-1:0] w);
        logic [WORD_WIDTH-1:0] r;
`ifdef CIRC_VEC_LOADER_CANON_EN
        if ((WORD_WIDTH == 31) && (w == {WORD_WIDTH{1'b1}})) begin
            r = {WORD_WIDTH{1'b0}};
        end else begin
            r = w;
        end
`else
        r = w;
`endif
        return r;
    endfunction

    logic [WORD_WIDTH-1:0] bank_r [0:1][0:MTX_SIZE-1];
    logic [1:0]            full_r;
    logic                  wr_bank_r;
    logic                  rd_bank_r;
    logic [IDX_W-1:0]      wr_idx_r;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  last_s;
    logic                  consume_s;
    logic [1:0]            full_nxt_s;

    // Handshake decode; accept-last and consume may coincide, they always touch different banks.
    always_comb begin
        in_ready_s = !full_r[wr_bank_r] && !in_flush;
        accept_s   = in_valid && in_ready_s;
        last_s     = accept_s && (wr_idx_r == LAST_IDX);
        consume_s  = full_r[rd_bank_r] && vec_ready;
        full_nxt_s = full_r;
        if (consume_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_r[rd_bank_r];
        end
        if (last_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_nxt_s[wr_bank_r];
        end
    end

    // Bank occupancy and read/write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_idx_r  <= {IDX_W{1'b0}};
        end else begin
            full_r <= full_nxt_s;
            if (consume_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
            if (in_flush) begin
                wr_idx_r <= {IDX_W{1'b0}};
            end else if (last_s) begin
                wr_idx_r  <= {IDX_W{1'b0}};
                wr_bank_r <= ~wr_bank_r;
            end else if (accept_s) begin
                wr_idx_r <= wr_idx_r + IDX_W'(1);
            end
        end
    end

    // Word storage; cleared on reset so vec reads zero until the first vector lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MTX_SIZE; i++) begin
                    bank_r[b][i] <= {WORD_WIDTH{1'b0}};
                end
            end
        end else if (accept_s) begin
            bank_r[wr_bank_r][wr_idx_r] <= canon_word(in_word);
        end
    end

    // Output view of the read bank and write-bank fill level.
    always_comb begin
        for (int i = 0; i < MTX_SIZE; i++) begin
            vec[i] = bank_r[rd_bank_r][i];
        end
        in_ready  = in_ready_s;
        vec_valid = full_r[rd_bank_r];
        if (full_r[wr_bank_r]) begin
            fill_cnt = CNT_W'(MTX_SIZE);
        end else begin
            fill_cnt = {1'b0, wr_idx_r};
        end
    end

endmodule

// File: tb/tb_circ_vec_loader.sv
// Self-checking bench for circ_vec_loader: queue-based reference model plus directed literal checks.
module tb_circ_vec_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [30:0] in_word = 31'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_flush = 1'b0;
    logic [30:0] vec [0:15];
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic [4:0]  fill_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    typedef logic [15:0][30:0] pvec_t;
    pvec_t       rq[$];
    logic [30:0] cur[$];
    logic [30:0] got_q[$];
    bit          ir_low;

    circ_vec_loader #(.WORD_WIDTH(31), .MTX_SIZE(16)) dut (
        .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .in_flush(in_flush), .vec(vec), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] mcanon(input logic [30:0] w);
`ifdef CIRC_VEC_LOADER_CANON_EN
        return (w == 31'h7FFFFFFF) ? 31'h0 : w;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words accumulate in cur, complete vectors queue in rq (at most two).
    always @(posedge clk or posedge reset) begin
        bit    rdy_e, cons, acc;
        pvec_t pv;
        if (reset) begin
            cur.delete();
            rq.delete();
        end else begin
            rdy_e = (rq.size() < 2) && (in_flush !== 1'b1);
            cons  = (rq.size() > 0) && (vec_ready === 1'b1);
            acc   = (in_valid === 1'b1) && rdy_e;
            if (cons) void'(rq.pop_front());
            if (in_flush === 1'b1) begin
                cur.delete();
            end else if (acc) begin
                cur.push_back(mcanon(in_word));
                if (cur.size() == 16) begin
                    for (int i = 0; i < 16; i++) pv[i] = cur[i];
                    rq.push_back(pv);
                    cur.delete();
                end
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        pvec_t pv;
        int    bad;
        #2;
        if (reset === 1'b0) begin
            chk("in_ready", 64'(in_ready), 64'((rq.size() < 2) && !in_flush));
            chk("vec_valid", 64'(vec_valid), 64'(rq.size() > 0));
            chk("fill_cnt", 64'(fill_cnt), (rq.size() == 2) ? 64'd16 : 64'(cur.size()));
            if (rq.size() > 0) begin
                pv  = rq[0];
                bad = 0;
                for (int i = 15; i >= 0; i--) if (vec[i] !== pv[i]) bad = i;
                chk("vec_word", 64'(vec[bad]), 64'(pv[bad]));
            end
        end
    end

    task automatic drive(input logic v, input logic [30:0] w, input logic fl, input logic rdy,
                         output logic acc);
        @(negedge clk);
        in_valid = v; in_word = w; in_flush = fl; vec_ready = rdy;
        #1;
        acc = v && in_ready;
        if (vec_valid && rdy) got_q.push_back(vec[0]);
        if (!in_ready) ir_low = 1'b1;
    endtask

    task automatic send_word(input logic [30:0] w, input logic rdy);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            drive(1'b1, w, 1'b0, rdy, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted after %0d cycles, acceptance required", w, tries);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; vec_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic acc;
        // 1: fill one vector with vec_ready low
        do_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_vec_valid", 64'(vec_valid), 64'd0);
        chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("rst_vec0", 64'(vec[0]), 64'd0);
        chk("rst_vec15", 64'(vec[15]), 64'd0);
        for (int w = 1; w <= 16; w++) send_word(31'(w), 1'b0);
        drive(1'b0, 31'h0, 1'b0, 1'b0, acc);
        chk("t1_vec_valid", 64'(vec_valid), 64'd1);
        chk("t1_fill_cnt", 64'(fill_cnt), 64'd0);
        for (int i = 0; i < 16; i++) chk("t1_vec", 64'(vec[i]), 64'(i + 1));

        // 2: continuous streaming with consumer always ready
        do_reset();
        ir_low = 1'b0;
        got_q.delete();
        for (int w = 0; w < 48; w++) send_word(31'(w), 1'b1);
        drive(1'b0, 31'h0, 1'b0, 1'b1, acc);
        chk("t2_nvec", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("t2_v0", 64'(got_q[0]), 64'd0);
            chk("t2_v1", 64'(got_q[1]), 64'd16);
            chk("t2_v2", 64'(got_q[2]), 64'd32);
        end
        chk("t2_in_ready_dropped", 64'(ir_low), 64'd0);

        // 3: both banks full stalls input; one consume reopens it
        do_reset();
        for (int w = 0; w < 32; w++) send_word(31'(w), 1'b0);
        drive(1'b1, 31'd32, 1'b0, 1'b0, acc);
        chk("t3_stall_in_ready", 64'(in_ready), 64'd0);
        chk("t3_vec0", 64'(vec[0]), 64'd0);
        chk("t3_vec15", 64'(vec[15]), 64'd15);
        drive(1'b1, 31'd32, 1'b0, 1'b1, acc);
        chk("t3_consume_cycle_acc", 64'(acc), 64'd0);
        drive(1'b1, 31'd32, 1'b0, 1'b0, acc);
        chk("t3_in_ready_rise", 64'(acc), 64'd1);
        chk("t3_vec0_b", 64'(vec[0]), 64'd16);
        chk("t3_vec15_b", 64'(vec[15]), 64'd31);
        for (int w = 33; w < 40; w++) send_word(31'(w), 1'b0);

        // 4: flush drops the partial vector and the flush-cycle beat
        do_reset();
        for (int w = 0; w < 5; w++) send_word(31'(w), 1'b0);
        drive(1'b1, 31'd999, 1'b1, 1'b0, acc);
        chk("t4_flush_acc", 64'(acc), 64'd0);
        for (int w = 100; w < 116; w++) send_word(31'(w), 1'b0);
        drive(1'b0, 31'h0, 1'b0, 1'b0, acc);
        chk("t4_vec_valid", 64'(vec_valid), 64'd1);
        chk("t4_vec0", 64'(vec[0]), 64'd100);
        chk("t4_vec15", 64'(vec[15]), 64'd115);

        // 5: modulus-valued word
        do_reset();
        send_word(31'h7FFFFFFF, 1'b0);
        send_word(31'h7FFFFFFE, 1'b0);
        for (int w = 0; w < 14; w++) send_word(31'h0, 1'b0);
        drive(1'b0, 31'h0, 1'b0, 1'b0, acc);
`ifdef CIRC_VEC_LOADER_CANON_EN
        chk("t5_vec0", 64'(vec[0]), 64'h0);
`else
        chk("t5_vec0", 64'(vec[0]), 64'h7FFFFFFF);
`endif
        chk("t5_vec1", 64'(vec[1]), 64'h7FFFFFFE);

        // 6: asynchronous reset mid-fill with one bank full
        do_reset();
        for (int w = 0; w < 23; w++) send_word(31'(w + 1), 1'b0);
        drive(1'b0, 31'h0, 1'b0, 1'b0, acc);
        chk("t6_pre_fill", 64'(fill_cnt), 64'd7);
        chk("t6_pre_valid", 64'(vec_valid), 64'd1);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_vec_valid", 64'(vec_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("t6_vec0", 64'(vec[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic        v, fl, rdy;
            logic [30:0] w;
            v   = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 7) == 0) ? 31'h7FFFFFFF : 31'($urandom);
            fl  = ($urandom_range(0, 24) == 0);
            rdy = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(v, w, fl, rdy, acc);
        end
        drive(1'b0, 31'h0, 1'b0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
